sram_burst_master: RTL and testbench
====================================

# sram_burst_master

Requester-side engine for the on-board SRAM word interface (`io_sram_*`). It accepts single or burst read/write commands on a valid/ready port, streams write data in and read data out with backpressure, and drives the SRAM port one beat per cycle. Read data is sampled one cycle after issue. A 2-entry return buffer absorbs consumer stalls. It sits between the cache/bus arbiter and the SRAM pin wrapper.

## Interface
- No parameters. Fixed widths: 20-bit word address, 32-bit data, 4-bit byte mask, 4-bit burst length.
- `clk` in 1: the single clock. All logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: command valid.
- `req_ready` out 1: command accept. It is high only in IDLE.
- `req_we` in 1: 1 = write burst, 0 = read burst.
- `req_addr` in 20: first word address.
- `req_len` in 4: beats minus 1, giving 1..16 beats.
- `req_wmask` in 4: byte mask applied to every write beat.
- `wdata_valid` in 1, `wdata_ready` out 1, `wdata` in 32: write-beat stream.
- `rdata_valid` out 1, `rdata_ready` in 1, `rdata` out 32, `rdata_last` out 1: read-beat stream.
- `done` out 1: one-cycle pulse when a burst completes.
- `io_sram_en` out 1, `io_sram_we` out 1, `io_sram_addr` out 20, `io_sram_din` out 32, `io_sram_wmask` out 4: SRAM request, sampled by the SRAM side each clock.
- `io_sram_dout` in 32: read data, valid during the cycle after the read beat was presented.

## Operation
- FSM states: IDLE, RD, RDW, WR, TURN.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`: latch addr, len, wmask and set beat counter = len. Go to WR if `req_we`, else RD.
- WR:
  - `wdata_ready`=1.
  - `io_sram_en`=`io_sram_we`=`wdata_valid`; `io_sram_din`=`wdata`; `io_sram_wmask`=latched mask.
  - Each handshake issues one beat and advances the address.
  - After the last beat, go to TURN.
- TURN: one idle cycle (`io_sram_en`=0) for bus turnaround, with `done`=1. Then IDLE.
- RD:
  - Issue a read beat (`io_sram_en`=1, `io_sram_we`=0) when `cnt + pend - pop < 2`.
    - `cnt` = buffer occupancy.
    - `pend` = beat issued last cycle and not yet captured.
    - `pop` = `rdata_valid & rdata_ready`.
  - At the clock edge ending the cycle after issue, capture `{last, io_sram_dout}` into the buffer.
  - After the last issue, go to RDW.
- RDW: wait until the last beat is captured. `done` pulses in the cycle that capture occurs (i.e. the capture edge), then go to IDLE.
- Return buffer: 2-entry FIFO. `rdata_valid` = not empty; head entry drives `rdata`/`rdata_last`. Push and pop may occur in the same cycle. The buffer drains independently of the FSM, so a new command may be accepted while entries remain.
- Address increment: `addr+1`, modulo 2^20. 0xFFFFF wraps to 0x00000.
- When `io_sram_en`=0, all other `io_sram_*` outputs are 0.
- Reset, including mid-burst: state returns to IDLE, buffer and `pend` cleared, burst abandoned with no `done`.
- Reset values:
  - All outputs are 0 while `rst` is high, including `req_ready`.
  - `req_ready` rises the first cycle after release.

## Timing
- Command accepted at edge E (end of cycle A). First SRAM beat is presented in cycle A+1.
- Read latency: beat in cycle T gives `rdata_valid` at T+2 at the earliest.
- With `rdata_ready` held 1, reads sustain 1 beat/cycle. An N-beat read occupies RD for N cycles plus 1 RDW cycle.
- If `rdata_ready` stays 0, at most 2 beats are outstanding. Issue stalls and `io_sram_en`=0 until a pop.
- A write burst takes N handshake cycles plus 1 TURN cycle.
- `wdata_valid` low stalls the burst, holding address and counter.
- `req_valid` is ignored outside IDLE and during reset.

## Configuration
- `SRAM_BURST_WRAP_EN` defined: wrapping bursts for critical-word-first refill.
  - Next address = `(addr & ~{16'b0,len}) | ((addr+1) & {16'b0,len})`, using the latched len as the wrap mask.
  - Software issues only len ∈ {0,1,3,7,15}.
- Not defined: incrementing bursts only, as in Operation. len is a plain count.

## Test plan
- Single read at 0x00010 with `rdata_ready`=1, SRAM returning 0xDEADBEEF:
  - `io_sram_en` high for 1 cycle.
  - `rdata`=0xDEADBEEF with `rdata_last`=1 at A+3.
  - `done` pulses once.
- 4-beat write from 0x00100 (mask 0b0011, data 1..4, `wdata_valid` dropped for 1 cycle after beat 2):
  - Addresses 0x100..0x103 in order, each with wmask 0b0011.
  - 1 stall cycle, then TURN with `done`.
- 8-beat read from 0x00020 with `rdata_ready`=0 for 5 cycles, then 1:
  - Exactly 2 beats issued before the stall; nothing lost or duplicated.
  - All 8 words delivered in order; `rdata_last` only on the 8th.
- 2-beat read at 0xFFFFF: addresses 0xFFFFF then 0x00000.
- `SRAM_BURST_WRAP_EN`, 4-beat read at 0x00006: addresses 6, 7, 4, 5.
- `rst` pulsed mid-way through a 16-beat read:
  - All outputs go to 0 immediately and the buffer is empty.
  - A new single read after release completes normally.

Source files
------------

// File: rtl/sram_burst_master.sv
// Burst read/write requester for the io_sram word port, with a 2-entry read return buffer.
// Define SRAM_BURST_WRAP_EN for wrapping (critical-word-first) bursts; default is incrementing.
module sram_burst_master (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [19:0] req_addr,
    input  logic [3:0]  req_len,
    input  logic [3:0]  req_wmask,
    input  logic        wdata_valid,
    output logic        wdata_ready,
    input  logic [31:0] wdata,
    output logic        rdata_valid,
    input  logic        rdata_ready,
    output logic [31:0] rdata,
    output logic        rdata_last,
    output logic        done,
    output logic        io_sram_en,
    output logic        io_sram_we,
    output logic [19:0] io_sram_addr,
    output logic [31:0] io_sram_din,
    output logic [3:0]  io_sram_wmask,
    input  logic [31:0] io_sram_dout
);
    typedef enum logic [2:0] {IDLE, RD, RDW, WR, TURN} state_t;

    state_t      state;
    logic [19:0] addr;
    logic [19:0] addr_nxt;
    logic [3:0]  mask;
    logic [3:0]  beats;
    logic        pend;
    logic        pend_last;
    logic [32:0] fifo_mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  buf_cnt;
    logic        pop;
    logic        issue_rd;
    logic        wr_hs;

`ifdef SRAM_BURST_WRAP_EN
    logic [3:0] len;

    // Low bits selected by len wrap within the aligned block; high bits stay fixed.
    function automatic logic [19:0] next_addr(input logic [19:0] a, input logic [3:0] l);
        return (a & ~{16'b0, l}) | ((a + 20'd1) & {16'b0, l});
    endfunction

    assign addr_nxt = next_addr(addr, len);
`else
    function automatic logic [19:0] next_addr(input logic [19:0] a);
        return a + 20'd1;
    endfunction

    assign addr_nxt = next_addr(addr);
`endif

    assign pop         = rdata_valid & rdata_ready;
    // Never let buffered + in-flight reads exceed the two buffer slots.
    assign issue_rd    = (state == RD) && (({1'b0, buf_cnt} + {2'b0, pend}) < (3'd2 + {2'b0, pop}));
    assign wr_hs       = (state == WR) && wdata_valid;
    assign wdata_ready = (state == WR);

    assign io_sram_en    = issue_rd | wr_hs;
    assign io_sram_we    = wr_hs;
    assign io_sram_addr  = io_sram_en ? addr : 20'd0;
    assign io_sram_din   = wr_hs ? wdata : 32'd0;
    assign io_sram_wmask = wr_hs ? mask : 4'd0;

    // RDW lasts exactly the cycle whose closing edge captures the final beat.
    assign done = (state == TURN) || (state == RDW);

    assign rdata_valid = (buf_cnt != 2'd0);
    assign rdata       = rdata_valid ? fifo_mem[rd_ptr][31:0] : 32'd0;
    assign rdata_last  = rdata_valid & fifo_mem[rd_ptr][32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            addr      <= 20'd0;
            mask      <= 4'd0;
            beats     <= 4'd0;
            pend      <= 1'b0;
            pend_last <= 1'b0;
`ifdef SRAM_BURST_WRAP_EN
            len       <= 4'd0;
`endif
        end else begin
            pend      <= issue_rd;
            pend_last <= issue_rd && (beats == 4'd0);
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        addr      <= req_addr;
                        mask      <= req_wmask;
                        beats     <= req_len;
`ifdef SRAM_BURST_WRAP_EN
                        len       <= req_len;
`endif
                        req_ready <= 1'b0;
                        state     <= req_we ? WR : RD;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                RD: begin
                    if (issue_rd) begin
                        addr <= addr_nxt;
                        if (beats == 4'd0) state <= RDW;
                        else beats <= beats - 4'd1;
                    end
                end
                WR: begin
                    if (wr_hs) begin
                        addr <= addr_nxt;
                        if (beats == 4'd0) state <= TURN;
                        else beats <= beats - 4'd1;
                    end
                end
                RDW, TURN: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Return buffer: SRAM data is captured one cycle after its read beat was issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            buf_cnt <= 2'd0;
        end else begin
            if (pend) wr_ptr <= ~wr_ptr;
            if (pop) rd_ptr <= ~rd_ptr;
            buf_cnt <= buf_cnt + {1'b0, pend} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (pend) fifo_mem[wr_ptr] <= {pend_last, io_sram_dout};
    end
endmodule

// File: tb/tb_sram_burst_master.sv
// Directed bench for sram_burst_master: scoreboard model of SRAM beats and read returns,
// plus literal address, latency and done-timing expectations per burst.
module tb_sram_burst_master;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [19:0] req_addr;
    logic [3:0]  req_len;
    logic [3:0]  req_wmask;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [31:0] wdata;
    logic        rdata_valid;
    logic        rdata_ready;
    logic [31:0] rdata;
    logic        rdata_last;
    logic        done;
    logic        io_sram_en;
    logic        io_sram_we;
    logic [19:0] io_sram_addr;
    logic [31:0] io_sram_din;
    logic [3:0]  io_sram_wmask;
    logic [31:0] io_sram_dout = 32'h0;

    sram_burst_master dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_len(req_len), .req_wmask(req_wmask),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .rdata_last(rdata_last), .done(done),
        .io_sram_en(io_sram_en), .io_sram_we(io_sram_we), .io_sram_addr(io_sram_addr),
        .io_sram_din(io_sram_din), .io_sram_wmask(io_sram_wmask), .io_sram_dout(io_sram_dout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [19:0] addr;
        logic [31:0] din;
        logic [3:0]  mask;
    } beat_t;

    beat_t       exp_beats[$];
    logic [32:0] exp_rd[$];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Per-burst expectations, written only by the stimulus process.
    int          t_id = 0;
    int          t_beats = 0;
    int          t_done_off = -1;
    int          t_rv_off = -1;
    int          t_stall_at = 0;
    int          t_nlit = 0;
    logic [19:0] t_lit [4];
    logic        t_rdata_lit_en = 1'b0;

    // Monitor state.
    int          seen_id = 0;
    int          fin_id = 0;
    int          acc_cyc = -1;
    int          en_count = 0;
    int          done_count = 0;
    int          pop_count = 0;
    int          outstanding = 0;
    int          since_rst = 2;
    logic        rd_pend = 1'b0;
    logic [19:0] rd_addr = 20'h0;
    beat_t       mb;
    logic [32:0] mr;
    logic [19:0] ma;
    logic [19:0] wm;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] data_of(input logic [19:0] a);
        if (a == 20'h00010) return 32'hDEADBEEF;
        return 32'hC0DE0000 ^ {12'h0, a};
    endfunction

    function automatic logic [19:0] beat_addr(input logic [19:0] base, input logic [19:0] wmask_in, input int i);
        logic [19:0] off;
        off = 20'(i);
        return (base & ~wmask_in) | ((base + off) & wmask_in);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // SRAM model: read data appears the cycle after the read beat.
    always @(posedge clk) begin
        #1;
        io_sram_dout = rd_pend ? data_of(rd_addr) : 32'h0;
    end

    always @(negedge clk) begin
        if (t_id != seen_id) begin
            seen_id    = t_id;
            en_count   = 0;
            done_count = 0;
            pop_count  = 0;
            acc_cyc    = -1;
        end
        if (rst) begin
            check("rst_ctrl_zero", 64'({req_ready, wdata_ready, rdata_valid, rdata_last, done,
                                        io_sram_en, io_sram_we, io_sram_wmask, io_sram_addr}), 64'd0);
            check("rst_data_zero", 64'({rdata, io_sram_din}), 64'd0);
            exp_beats.delete();
            exp_rd.delete();
            outstanding = 0;
            rd_pend     = 1'b0;
            since_rst   = 0;
        end else begin
            if (since_rst == 0) check("ready_low_at_release", 64'({req_ready, rdata_valid}), 64'd0);
            else if (since_rst == 1) check("ready_high_next_cycle", 64'(req_ready), 64'd1);
            if (since_rst < 2) since_rst++;

            if (req_valid && req_ready) begin
                acc_cyc = cyc;
`ifdef SRAM_BURST_WRAP_EN
                wm = {16'b0, req_len};
`else
                wm = 20'hFFFFF;
`endif
                for (int i = 0; i <= int'(req_len); i++) begin
                    ma = beat_addr(req_addr, wm, i);
                    if (req_we) begin
                        exp_beats.push_back(beat_t'({1'b1, ma, 32'(i + 1), req_wmask}));
                    end else begin
                        exp_beats.push_back(beat_t'({1'b0, ma, 32'h0, 4'h0}));
                        exp_rd.push_back({(i == int'(req_len)), data_of(ma)});
                    end
                end
            end

            if (rdata_valid && rdata_ready) begin
                check("rdata_expected", 64'(exp_rd.size() > 0), 64'd1);
                if (exp_rd.size() > 0) begin
                    mr = exp_rd.pop_front();
                    check("rdata", 64'({rdata_last, rdata}), 64'(mr));
                end
                if (pop_count == 0 && t_rv_off >= 0) check("rdata_latency", 64'(cyc - acc_cyc), 64'(t_rv_off));
                if (pop_count == 0 && t_rdata_lit_en) check("rdata_literal", 64'({rdata_last, rdata}), 64'h1_DEADBEEF);
                pop_count++;
                outstanding--;
            end

            if (io_sram_en) begin
                check("beat_expected", 64'(exp_beats.size() > 0), 64'd1);
                if (exp_beats.size() > 0) begin
                    mb = exp_beats.pop_front();
                    check("sram_beat", 64'({io_sram_we, io_sram_addr, io_sram_din, io_sram_wmask}), 64'(mb));
                end
                if (en_count < t_nlit) check("beat_addr_literal", 64'(io_sram_addr), 64'(t_lit[en_count]));
                if (en_count == 0) check("first_beat_latency", 64'(cyc - acc_cyc), 64'd1);
                if (!io_sram_we) begin
                    outstanding++;
                    check("outstanding_le2", 64'(outstanding <= 2), 64'd1);
                    rd_pend = 1'b1;
                    rd_addr = io_sram_addr;
                end else begin
                    rd_pend = 1'b0;
                end
                en_count++;
            end else begin
                rd_pend = 1'b0;
                check("idle_port_zero", 64'({io_sram_we, io_sram_wmask, io_sram_addr, io_sram_din}), 64'd0);
            end

            if (t_stall_at > 0 && acc_cyc >= 0 && (cyc - acc_cyc) == t_stall_at)
                check("stall_issue_cap", 64'(en_count), 64'd2);

            if (done) begin
                check("done_once", 64'(done_count), 64'd0);
                if (t_done_off >= 0) check("done_cycle", 64'(cyc - acc_cyc), 64'(t_done_off));
                done_count++;
            end

            if (acc_cyc >= 0 && done_count > 0 && exp_beats.size() == 0 && exp_rd.size() == 0 && fin_id != seen_id) begin
                check("beat_count", 64'(en_count), 64'(t_beats));
                fin_id = seen_id;
            end
        end
    end

    task automatic start_test(input int beats, input int done_off, input int rv_off, input int stall_at,
                              input int nlit, input logic [19:0] l0, input logic [19:0] l1,
                              input logic [19:0] l2, input logic [19:0] l3, input logic lit_rd);
        t_beats = beats; t_done_off = done_off; t_rv_off = rv_off; t_stall_at = stall_at;
        t_nlit = nlit; t_lit[0] = l0; t_lit[1] = l1; t_lit[2] = l2; t_lit[3] = l3;
        t_rdata_lit_en = lit_rd;
        t_id++;
    endtask

    task automatic send_cmd(input logic we, input logic [19:0] a, input logic [3:0] l, input logic [3:0] m);
        int n;
        n = 0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_len = l; req_wmask = m;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            $display("FAIL cmd_accept_timeout: req_ready=0 required=1");
            $fatal(1, "command never accepted");
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = ~we; req_addr = 20'h5A5A5; req_len = 4'hF; req_wmask = 4'hC;
    endtask

    task automatic write_beats(input int n, input int stall_at);
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                wdata_valid = 1'b0; wdata = 32'hBAD00000;
                @(posedge clk); #1;
            end
            wdata_valid = 1'b1; wdata = 32'(i + 1);
            @(posedge clk); #1;
        end
        wdata_valid = 1'b0; wdata = 32'h0;
    endtask

    task automatic wait_fin();
        int n;
        n = 0;
        while (fin_id != t_id && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (fin_id != t_id) begin
            $display("FAIL burst_timeout: test %0d completed=0 required=1", t_id);
            $fatal(1, "burst did not complete");
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 20'h0; req_len = 4'h0; req_wmask = 4'h0;
        wdata_valid = 1'b0; wdata = 32'h0; rdata_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Single read at 0x10: beat at A+1, done at A+2, data at A+3.
        start_test(1, 2, 3, 0, 1, 20'h00010, 20'h0, 20'h0, 20'h0, 1'b1);
        send_cmd(1'b0, 20'h00010, 4'd0, 4'h0);
        wait_fin();

        // 4-beat write with one wdata stall before the third beat.
        start_test(4, 6, -1, 0, 4, 20'h00100, 20'h00101, 20'h00102, 20'h00103, 1'b0);
        send_cmd(1'b1, 20'h00100, 4'd3, 4'b0011);
        write_beats(4, 2);
        wait_fin();

        // 8-beat read with the consumer stalled for five cycles.
        rdata_ready = 1'b0;
        start_test(8, 12, 6, 5, 2, 20'h00020, 20'h00021, 20'h0, 20'h0, 1'b0);
        send_cmd(1'b0, 20'h00020, 4'd7, 4'h0);
        repeat (5) @(posedge clk);
        #1 rdata_ready = 1'b1;
        wait_fin();

        // 2-beat read at the top of the address space.
`ifdef SRAM_BURST_WRAP_EN
        start_test(2, 3, 3, 0, 2, 20'hFFFFF, 20'hFFFFE, 20'h0, 20'h0, 1'b0);
`else
        start_test(2, 3, 3, 0, 2, 20'hFFFFF, 20'h00000, 20'h0, 20'h0, 1'b0);
`endif
        send_cmd(1'b0, 20'hFFFFF, 4'd1, 4'h0);
        wait_fin();

        // 4-beat read at 0x6.
`ifdef SRAM_BURST_WRAP_EN
        start_test(4, 5, 3, 0, 4, 20'h00006, 20'h00007, 20'h00004, 20'h00005, 1'b0);
`else
        start_test(4, 5, 3, 0, 4, 20'h00006, 20'h00007, 20'h00008, 20'h00009, 1'b0);
`endif
        send_cmd(1'b0, 20'h00006, 4'd3, 4'h0);
        wait_fin();

        // 16-beat read abandoned by reset; no done may appear.
        start_test(16, 99, 3, 0, 2, 20'h00200, 20'h00201, 20'h0, 20'h0, 1'b0);
        send_cmd(1'b0, 20'h00200, 4'd15, 4'h0);
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single read after reset completes normally.
        start_test(1, 2, 3, 0, 1, 20'h00010, 20'h0, 20'h0, 20'h0, 1'b1);
        send_cmd(1'b0, 20'h00010, 4'd0, 4'h0);
        wait_fin();

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
